// File: rtl/dmem_responder.sv
// Data-memory slave for the core's data port: RV32I byte/half/word loads and stores,
// configurable wait states, one-cycle completion pulse and illegal-access flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        mem_ready,
    output logic        mem_err
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_M1     = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH+1:0]   addr_r;
    logic [31:0]             data_r;
    logic [2:0]              type_r;
    logic                    rd_r;
    logic                    wr_r;
    logic [31:0]             ram_r [DEPTH];

    logic [ADDR_WIDTH+1:0]   addr_s;
    logic [31:0]             data_s;
    logic [2:0]              type_s;
    logic                    rd_s;
    logic                    wr_s;
    logic                    commit_s;
    logic                    err_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [31:0]             old_word_s;
    logic [31:0]             store_word_s;
    logic [31:0]             load_word_s;
    logic                    unused_s;

    assign unused_s = ^Addr_in[31:ADDR_WIDTH+2];

    function automatic logic f_err(input logic rd, input logic wr,
                                   input logic [2:0] t, input logic [1:0] a);
        logic e;
        case (t)
            3'b000, 3'b100: e = 1'b0;
            3'b001, 3'b101: e = a[0];
            3'b010:         e = (a != 2'b00);
            default:        e = 1'b1;
        endcase
        return e | (wr & t[2]) | (rd & wr);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [2:0] t, input logic [1:0] a);
        logic [31:0] n;
        n = w;
        case (t[1:0])
            2'b00:   n[{a, 3'b000} +: 8]    = d[7:0];
            2'b01:   n[{a[1], 4'b0000} +: 16] = d[15:0];
            default: n = d;
        endcase
        return n;
    endfunction

    // In IDLE the live inputs describe the access (zero-wait commits on the accept edge)
    always_comb begin
        addr_s   = addr_r;
        data_s   = data_r;
        type_s   = type_r;
        rd_s     = rd_r;
        wr_s     = wr_r;
        commit_s = 1'b0;
        if (state_r == S_IDLE) begin
            addr_s   = Addr_in[ADDR_WIDTH+1:0];
            data_s   = Data_in;
            type_s   = DMType;
            rd_s     = mem_r;
            wr_s     = mem_w;
            commit_s = (mem_r | mem_w) & ZERO_WAIT;
        end else if (state_r == S_WAIT) begin
            commit_s = (cnt_r == 4'd0);
        end else begin
            commit_s = 1'b0;
        end
    end

    assign idx_s        = addr_s[ADDR_WIDTH+1:2];
    assign old_word_s   = ram_r[idx_s];
    assign err_s        = f_err(rd_s, wr_s, type_s, addr_s[1:0]);
    assign store_word_s = f_merge(old_word_s, data_s, type_s, addr_s[1:0]);
    assign load_word_s  = f_load(old_word_s, type_s, addr_s[1:0]);

    // Array write on commit; held off while reset is asserted so an aborted store never lands
    always_ff @(posedge clk) begin
        if (commit_s && wr_s && !err_s && reset) begin
            ram_r[idx_s] <= store_word_s;
        end
    end

    // Access FSM with registered completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= '0;
            data_r    <= 32'd0;
            type_r    <= 3'd0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            Data_out  <= 32'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= commit_s;
            if (commit_s) begin
                mem_err <= err_s;
                if (err_s) begin
                    Data_out <= 32'd0;
                end else if (rd_s) begin
                    Data_out <= load_word_s;
                end
            end
            case (state_r)
                S_IDLE: begin
                    if (mem_r | mem_w) begin
                        addr_r  <= Addr_in[ADDR_WIDTH+1:0];
                        data_r  <= Data_in;
                        type_r  <= DMType;
                        rd_r    <= mem_r;
                        wr_r    <= mem_w;
                        cnt_r   <= WS_M1;
                        state_r <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= S_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has no wait states, instance 1 has three.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst   [2];
    logic        mr    [2];
    logic        mw    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  ty    [2];
    logic [31:0] dout  [2];
    logic        rdy   [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[0]), .mem_r(mr[0]), .mem_w(mw[0]), .Addr_in(addr[0]),
        .Data_in(wdata[0]), .DMType(ty[0]), .Data_out(dout[0]), .mem_ready(rdy[0]),
        .mem_err(err[0]));

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst[1]), .mem_r(mr[1]), .mem_w(mw[1]), .Addr_in(addr[1]),
        .Data_in(wdata[1]), .DMType(ty[1]), .Data_out(dout[1]), .mem_ready(rdy[1]),
        .mem_err(err[1]));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One complete access: latency, data, error flag and single-cycle pulse
    task automatic do_access(input int d, input logic rd, input logic wr, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] ed, input logic ee, input string nm);
        int n;
        @(negedge clk);
        mr[d] = rd; mw[d] = wr; ty[d] = t; addr[d] = a; wdata[d] = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy[d] && n < 20);
        mr[d] = 1'b0; mw[d] = 1'b0;
        chk({nm, " latency"}, 32'(n), (d == 0) ? 32'd1 : 32'd4);
        chk({nm, " data"}, dout[d], ed);
        chk({nm, " err"}, {31'd0, err[d]}, {31'd0, ee});
        @(posedge clk); #1;
        chk({nm, " pulse"}, {31'd0, rdy[d]}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0;
            addr[i] = 32'd0; wdata[i] = 32'd0; ty[i] = 3'd0;
        end

        //            rd    wr    type    addr          wdata         exp data      exp err
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h00000011, 32'h000000AA, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h00000011, 32'h0,        32'hFFFFFFAA, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h00000011, 32'h0,        32'h000000AA, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEADAAEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h00000012, 32'h00008001, 32'hDEADAAEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h00000012, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b101, 32'h00000012, 32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'h8001AAEF, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h00000013, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h00000011, 32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h00000010, 32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h00000010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'h8001AAEF, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b100, 32'h00000010, 32'h00000000, 32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 3'b110, 32'h00000010, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'h8001AAEF, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 3'b000, 32'h00000013, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 3'b100, 32'h00000010, 32'h0,        32'h000000EF, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'b001, 32'h00000010, 32'h0,        32'hFFFFAAEF, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 3'b010, 32'h00001010, 32'h0,        32'h8001AAEF, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset dout%0d", i), dout[i], 32'd0);
            chk($sformatf("reset rdy%0d", i), {31'd0, rdy[i]}, 32'd0);
            chk($sformatf("reset err%0d", i), {31'd0, err[i]}, 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;

        for (int i = 0; i < 22; i++) begin
            do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].t, vecs[i].a, vecs[i].wd,
                      vecs[i].ed, vecs[i].ee, $sformatf("vec%0d", i));
        end

        // Three wait states: seed two words
        do_access(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "ws3 sw20");
        do_access(1, 1'b0, 1'b1, 3'b010, 32'h24, 32'h11111111, 32'h0, 1'b0, "ws3 sw24");

        // Held load, address moved during WAIT must not matter
        @(negedge clk);
        mr[1] = 1'b1; ty[1] = 3'b010; addr[1] = 32'h20;
        @(posedge clk); #1;
        addr[1] = 32'h24;
        chk("ws3 wait0 rdy", {31'd0, rdy[1]}, 32'd0);
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ws3 wait%0d rdy", c), {31'd0, rdy[1]}, 32'd0);
        end
        @(posedge clk); #1;
        chk("ws3 ready", {31'd0, rdy[1]}, 32'd1);
        chk("ws3 data", dout[1], 32'hCAFEF00D);
        chk("ws3 err", {31'd0, err[1]}, 32'd0);
        mr[1] = 1'b0;
        @(posedge clk); #1;
        chk("ws3 single pulse", {31'd0, rdy[1]}, 32'd0);

        // Store aborted by reset while waiting
        @(negedge clk);
        mw[1] = 1'b1; ty[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        mw[1] = 1'b0;
        #1;
        chk("abort dout", dout[1], 32'd0);
        chk("abort rdy", {31'd0, rdy[1]}, 32'd0);
        chk("abort err", {31'd0, err[1]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort held rdy", {31'd0, rdy[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        do_access(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ws3 after abort");
        do_access(1, 1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 32'h00000000, 1'b1, "ws3 misaligned");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
